// File: rtl/pu_demultiplexer.sv
// Demultiplexer PU: routes tagged bus words into holding slots,
// then drains valid slots onto the bus in round-robin order.
module pu_demultiplexer #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int SEL_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel_active,
    input  logic                  data_active,
    input  logic                  out_active,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  empty,
    output logic                  underflow
);

    localparam int N_SLOTS = 2 ** SEL_WIDTH;

    logic [SEL_WIDTH-1:0]  sel;
    logic [SEL_WIDTH-1:0]  rd_ptr;
    logic [SEL_WIDTH-1:0]  pop_idx;
    logic [SEL_WIDTH-1:0]  cand;
    logic                  pop_hit;
    logic [N_SLOTS-1:0]    valid;
    logic [N_SLOTS-1:0]    valid_nxt;
    logic [DATA_WIDTH-1:0] slot_data [N_SLOTS];
    logic [ATTR_WIDTH-1:0] slot_attr [N_SLOTS];

    // Cyclic search from rd_ptr; index arithmetic wraps at N_SLOTS.
    always_comb begin
        pop_hit = 1'b0;
        pop_idx = rd_ptr;
        cand    = rd_ptr;
        for (int i = 0; i < N_SLOTS; i++) begin
            cand = rd_ptr + SEL_WIDTH'(i);
            if (!pop_hit && valid[cand]) begin
                pop_hit = 1'b1;
                pop_idx = cand;
            end
        end
    end

    // The write is applied after the clear so a same-slot write survives.
    always_comb begin
        valid_nxt = valid;
        if (out_active && pop_hit) begin
            valid_nxt[pop_idx] = 1'b0;
        end
        if (data_active) begin
            valid_nxt[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                slot_data[i] <= '0;
                slot_attr[i] <= '0;
            end
        end else if (data_active) begin
            slot_data[sel] <= data_in;
            slot_attr[sel] <= attr_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel   <= '0;
            valid <= '0;
        end else begin
            valid <= valid_nxt;
            if (sel_active) begin
                sel <= data_in[SEL_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            data_out  <= '0;
            attr_out  <= '0;
            underflow <= 1'b0;
        end else if (out_active && pop_hit) begin
            data_out <= slot_data[pop_idx];
            attr_out <= slot_attr[pop_idx];
            rd_ptr   <= pop_idx + SEL_WIDTH'(1);
        end else begin
            data_out <= '0;
            attr_out <= '0;
            if (out_active) begin
                underflow <= 1'b1;
            end
        end
    end

    assign empty = ~|valid;

endmodule

// File: tb/tb_pu_demultiplexer.sv
// Bench for pu_demultiplexer: directed vector table, async reset
// sequence, then random traffic against a slot-array reference model.
module tb_pu_demultiplexer;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SW = 1;
    localparam int N  = 2 ** SW;
    localparam int NV = 27;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sel_active;
    logic          data_active;
    logic          out_active;
    logic [DW-1:0] data_in;
    logic [AW-1:0] attr_in;
    logic [DW-1:0] data_out;
    logic [AW-1:0] attr_out;
    logic          empty;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    pu_demultiplexer #(
        .DATA_WIDTH(DW),
        .ATTR_WIDTH(AW),
        .SEL_WIDTH (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_active (sel_active),
        .data_active(data_active),
        .out_active (out_active),
        .data_in    (data_in),
        .attr_in    (attr_in),
        .data_out   (data_out),
        .attr_out   (attr_out),
        .empty      (empty),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sa;
        logic          da;
        logic          oa;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        logic [AW-1:0] ea;
        logic          ee;
        logic          eu;
    } vec_t;

    vec_t tbl [NV];

    // Reference model state
    logic [DW-1:0] m_data [N];
    logic [AW-1:0] m_attr [N];
    bit            m_valid [N];
    int            m_sel;
    int            m_rd;
    bit            m_uf;

    function automatic vec_t mk(
        input logic sa, input logic da, input logic oa,
        input logic [DW-1:0] d, input logic [AW-1:0] a,
        input logic [DW-1:0] ed, input logic [AW-1:0] ea,
        input logic ee, input logic eu);
        vec_t v;
        v.sa = sa; v.da = da; v.oa = oa; v.d = d; v.a = a;
        v.ed = ed; v.ea = ea; v.ee = ee; v.eu = eu;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] ed,
                         input logic [AW-1:0] ea, input logic ee,
                         input logic eu);
        checks++;
        if ({data_out, attr_out, empty, underflow} !== {ed, ea, ee, eu}) begin
            errors++;
            $display("FAIL %s: got d=%h a=%h empty=%b uf=%b want d=%h a=%h empty=%b uf=%b",
                     name, data_out, attr_out, empty, underflow, ed, ea, ee, eu);
        end
    endtask

    task automatic drive(input logic sa, input logic da, input logic oa,
                         input logic [DW-1:0] d, input logic [AW-1:0] a);
        @(negedge clk);
        sel_active  = sa;
        data_active = da;
        out_active  = oa;
        data_in     = d;
        attr_in     = a;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_data[i]  = '0;
            m_attr[i]  = '0;
            m_valid[i] = 0;
        end
        m_sel = 0;
        m_rd  = 0;
        m_uf  = 0;
    endtask

    task automatic model_step(input logic sa, input logic da, input logic oa,
                              input logic [DW-1:0] d, input logic [AW-1:0] a,
                              output logic [DW-1:0] ed, output logic [AW-1:0] ea,
                              output logic ee);
        int k;
        ed = '0;
        ea = '0;
        if (oa) begin
            k = -1;
            for (int j = 0; j < N; j++) begin
                if (k < 0 && m_valid[(m_rd + j) % N]) k = (m_rd + j) % N;
            end
            if (k >= 0) begin
                ed = m_data[k];
                ea = m_attr[k];
                m_valid[k] = 0;
                m_rd = (k + 1) % N;
            end else begin
                m_uf = 1;
            end
        end
        if (da) begin
            m_data[m_sel]  = d;
            m_attr[m_sel]  = a;
            m_valid[m_sel] = 1;
        end
        if (sa) m_sel = int'(d) % N;
        ee = 1;
        for (int j = 0; j < N; j++) if (m_valid[j]) ee = 0;
    endtask

    initial begin
        logic [DW-1:0] ed;
        logic [AW-1:0] ea;
        logic          ee;
        logic          sa, da, oa;
        logic [DW-1:0] d;
        logic [AW-1:0] a;

        // Two slots: write both, pop both
        tbl[0]  = mk(0,1,0, 32'hAAAA_AAAA, 4'hA, 0, 0, 0, 0);
        tbl[1]  = mk(1,0,0, 32'h0000_0001, 4'h0, 0, 0, 0, 0);
        tbl[2]  = mk(0,1,0, 32'h5555_5555, 4'h5, 0, 0, 0, 0);
        tbl[3]  = mk(0,0,1, 0, 0, 32'hAAAA_AAAA, 4'hA, 0, 0);
        tbl[4]  = mk(0,0,1, 0, 0, 32'h5555_5555, 4'h5, 1, 0);
        tbl[5]  = mk(0,0,0, 0, 0, 0, 0, 1, 0);
        // Round-robin wrap
        tbl[6]  = mk(0,1,0, 32'h0000_0B0B, 4'hB, 0, 0, 0, 0);
        tbl[7]  = mk(0,0,1, 0, 0, 32'h0000_0B0B, 4'hB, 1, 0);
        tbl[8]  = mk(1,0,0, 32'h0000_0000, 0, 0, 0, 1, 0);
        tbl[9]  = mk(0,1,0, 32'h0000_0C0C, 4'hC, 0, 0, 0, 0);
        tbl[10] = mk(1,0,0, 32'h0000_0001, 0, 0, 0, 0, 0);
        tbl[11] = mk(0,1,0, 32'h0000_0D0D, 4'hD, 0, 0, 0, 0);
        tbl[12] = mk(0,0,1, 0, 0, 32'h0000_0C0C, 4'hC, 0, 0);
        tbl[13] = mk(0,0,1, 0, 0, 32'h0000_0D0D, 4'hD, 1, 0);
        // Overwrite, then underflow; upper sel bits ignored
        tbl[14] = mk(1,0,0, 32'hFFFF_FFF0, 0, 0, 0, 1, 0);
        tbl[15] = mk(0,1,0, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
        tbl[16] = mk(0,1,0, 32'h1234_5678, 4'h3, 0, 0, 0, 0);
        tbl[17] = mk(0,0,1, 0, 0, 32'h1234_5678, 4'h3, 1, 0);
        tbl[18] = mk(0,0,1, 0, 0, 0, 0, 1, 1);
        // Simultaneous write and pop of the same slot
        tbl[19] = mk(0,1,0, 32'h1111_1111, 4'h1, 0, 0, 0, 1);
        tbl[20] = mk(0,1,1, 32'h2222_2222, 4'h2, 32'h1111_1111, 4'h1, 0, 1);
        tbl[21] = mk(0,0,1, 0, 0, 32'h2222_2222, 4'h2, 1, 1);
        // sel update and write in the same cycle use the old sel
        tbl[22] = mk(1,0,0, 32'h0000_0001, 0, 0, 0, 1, 1);
        tbl[23] = mk(1,1,0, 32'h6666_6660, 4'h6, 0, 0, 0, 1);
        tbl[24] = mk(0,1,0, 32'h7777_7777, 4'h7, 0, 0, 0, 1);
        tbl[25] = mk(0,0,1, 0, 0, 32'h6666_6660, 4'h6, 0, 1);
        tbl[26] = mk(0,0,1, 0, 0, 32'h7777_7777, 4'h7, 1, 1);

        rst_n = 1'b0;
        sel_active = 0; data_active = 0; out_active = 0;
        data_in = '0; attr_in = '0;
        #12;
        check("reset_state", 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].sa, tbl[i].da, tbl[i].oa, tbl[i].d, tbl[i].a);
            check($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ea, tbl[i].ee, tbl[i].eu);
        end

        // Async reset mid-operation discards held data
        drive(0, 1, 0, 32'h9999_9999, 4'h9);
        drive(0, 1, 1, 32'h8888_8888, 4'h8);
        check("pre_reset_pop", 32'h9999_9999, 4'h9, 0, 1);
        @(negedge clk);
        sel_active = 0; data_active = 0; out_active = 0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", 0, 0, 1, 0);
        @(posedge clk);
        #1 check("reset_hold", 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 1, 0, 0);
        check("post_reset_pop", 0, 0, 1, 1);

        model_reset();
        m_uf = 1;
        for (int i = 0; i < 400; i++) begin
            sa = ($urandom_range(0, 3) == 0);
            da = ($urandom_range(0, 1) == 0);
            oa = ($urandom_range(0, 2) == 0);
            d  = $urandom;
            a  = AW'($urandom_range(0, 15));
            model_step(sa, da, oa, d, a, ed, ea, ee);
            drive(sa, da, oa, d, a);
            check($sformatf("rand%0d", i), ed, ea, ee, m_uf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
